// File: rtl/note_tone_gen_if.sv
// Note/tone bus between the note-divider controller (master) and the tone generator (slave).
// The controller drives the requested period and volume; the generator returns the tone.
interface note_tone_gen_if;
    logic [19:0] note_div;
    logic [2:0]  volume;
    logic        square;
    logic [15:0] sample;
    logic        active;
    logic        note_load;

    modport master (
        output note_div, volume,
        input  square, sample, active, note_load
    );

    modport slave (
        input  note_div, volume,
        output square, sample, active, note_load
    );
endinterface

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: full period = note_div clocks, note changes only at half-period
// boundaries, with a volume-scaled signed 16-bit PCM sample alongside the 1-bit square.
module note_tone_gen #(
    parameter logic [15:0] AMP     = 16'h7FFF,
    parameter logic [19:0] MIN_DIV = 20'd2
) (
    input  logic           clk,
    input  logic           rst_n,
    note_tone_gen_if.slave bus
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t      state_q, state_d;
    logic [19:0] active_div_q, active_div_d;
    logic [18:0] cnt_q, cnt_d;
    logic        square_q, square_d;
    logic        active_q, active_d;
    logic        note_load_q, note_load_d;
    logic [15:0] sample_q, sample_d;

    logic [19:0] req;
    logic [18:0] half;
    logic        boundary;
    logic [15:0] mag;

    // Requests below MIN_DIV cannot form a tone, so they collapse to silence.
    assign req      = (bus.note_div >= MIN_DIV) ? bus.note_div : 20'd0;
    assign half     = active_div_q[19:1];
    assign boundary = (cnt_q == half - 19'd1);
    assign mag      = AMP >> bus.volume;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            active_div_q <= 20'd0;
            cnt_q        <= 19'd0;
            square_q     <= 1'b0;
            active_q     <= 1'b0;
            note_load_q  <= 1'b0;
            sample_q     <= 16'd0;
        end else begin
            state_q      <= state_d;
            active_div_q <= active_div_d;
            cnt_q        <= cnt_d;
            square_q     <= square_d;
            active_q     <= active_d;
            note_load_q  <= note_load_d;
            sample_q     <= sample_d;
        end
    end

    // The period latch only happens at a half-period boundary so the speaker never sees a runt pulse.
    always_comb begin
        state_d      = state_q;
        active_div_d = active_div_q;
        cnt_d        = cnt_q;
        square_d     = square_q;
        active_d     = active_q;
        note_load_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d    = 19'd0;
                square_d = 1'b0;
                active_d = 1'b0;
                if (req != 20'd0) begin
                    state_d      = PLAY;
                    active_div_d = req;
                    square_d     = 1'b1;
                    active_d     = 1'b1;
                    note_load_d  = 1'b1;
                end
            end
            PLAY: begin
                if (boundary) begin
                    cnt_d    = 19'd0;
                    square_d = ~square_q;
                    if (req != active_div_q) begin
                        active_div_d = req;
                        note_load_d  = 1'b1;
                        if (req == 20'd0) begin
                            state_d  = IDLE;
                            square_d = 1'b0;
                            active_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 19'd1;
                end
            end
            default: begin
                state_d      = IDLE;
                active_div_d = 20'd0;
                cnt_d        = 19'd0;
                square_d     = 1'b0;
                active_d     = 1'b0;
            end
        endcase
    end

    // The sample tracks the next-state tone so it lines up with the registered square.
    always_comb begin
        sample_d = 16'd0;
        if (active_d)
            sample_d = square_d ? mag : (16'd0 - mag);
    end

    assign bus.square    = square_q;
    assign bus.sample    = sample_q;
    assign bus.active    = active_q;
    assign bus.note_load = note_load_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Self-checking bench for note_tone_gen: a down-counting reference model pushes the expected
// outputs for each edge into a queue, which is popped and compared after the edge.
module tb_note_tone_gen;

    logic clk;
    logic rst_n;

    note_tone_gen_if bus ();

    note_tone_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sq;
        logic [15:0] smp;
        logic        act;
        logic        ld;
    } exp_t;

    exp_t exp_q[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state: remaining cycles in the current half-period.
    int   m_div;
    int   m_left;
    logic m_sq;
    logic m_act;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_div  = 0;
        m_left = 0;
        m_sq   = 1'b0;
        m_act  = 1'b0;
        exp_q.delete();
    endtask

    function automatic exp_t modelStep(input int nd, input int vol);
        exp_t e;
        int   req;
        int   mag;
        logic ld;
        req = (nd >= 2) ? nd : 0;
        ld  = 1'b0;
        if (!m_act) begin
            if (req != 0) begin
                m_div  = req;
                m_left = req / 2;
                m_sq   = 1'b1;
                m_act  = 1'b1;
                ld     = 1'b1;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_sq   = ~m_sq;
                m_left = m_div / 2;
                if (req != m_div) begin
                    m_div = req;
                    ld    = 1'b1;
                    if (req == 0) begin
                        m_sq  = 1'b0;
                        m_act = 1'b0;
                    end else begin
                        m_left = req / 2;
                    end
                end
            end
        end
        mag   = 32767 >> vol;
        e.sq  = m_sq;
        e.act = m_act;
        e.ld  = ld;
        e.smp = !m_act ? 16'd0 : (m_sq ? 16'(mag) : 16'(-mag));
        return e;
    endfunction

    // Drives the inputs for n edges; each edge's expectation is queued before it and checked after it.
    task automatic applyStimulus(input logic [19:0] nd, input logic [2:0] vol, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            bus.note_div = nd;
            bus.volume   = vol;
            exp_q.push_back(modelStep(int'(nd), int'(vol)));
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checkOutput("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("square",    32'(bus.square),    32'(e.sq));
                checkOutput("sample",    32'(bus.sample),    32'(e.smp));
                checkOutput("active",    32'(bus.active),    32'(e.act));
                checkOutput("note_load", 32'(bus.note_load), 32'(e.ld));
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_square"},    32'(bus.square),    32'd0);
        checkOutput({tag, "_sample"},    32'(bus.sample),    32'd0);
        checkOutput({tag, "_active"},    32'(bus.active),    32'd0);
        checkOutput({tag, "_note_load"}, 32'(bus.note_load), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.note_div = 20'd0;
        bus.volume   = 3'd0;
        modelReset();
        #12;
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] idle then note_div=8");
        applyStimulus(20'd0, 3'd0, 3);
        applyStimulus(20'd8, 3'd0, 18);

        $display("[TB] switch 8 -> 12 mid half-period");
        applyStimulus(20'd12, 3'd0, 30);

        $display("[TB] back to 8, then silence");
        applyStimulus(20'd8, 3'd0, 14);
        applyStimulus(20'd0, 3'd0, 14);

        $display("[TB] note_div=1 then 2");
        applyStimulus(20'd1, 3'd0, 6);
        applyStimulus(20'd2, 3'd0, 10);
        applyStimulus(20'd0, 3'd0, 3);

        $display("[TB] volume steps");
        applyStimulus(20'd8, 3'd0, 6);
        applyStimulus(20'd8, 3'd3, 5);
        applyStimulus(20'd8, 3'd7, 5);

        $display("[TB] async reset mid-tone");
        #3;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        modelReset();
        @(posedge clk);
        #1;
        checkAllZero("held_reset");
        rst_n = 1'b1;
        applyStimulus(20'd8, 3'd0, 12);

        $display("[TB] largest period");
        applyStimulus(20'hFFFFF, 3'd1, 10);
        #2;
        rst_n = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] random note/volume changes");
        for (int k = 0; k < 25; k++) begin
            logic [19:0] nd;
            nd = 20'($urandom_range(0, 14));
            applyStimulus(nd, 3'($urandom_range(0, 7)), int'($urandom_range(1, 9)));
        end
        applyStimulus(20'd0, 3'd0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Downstream consumer of the note-divider controller's 20-bit note_div word.
- Generates a glitch-free square-wave tone whose full period equals note_div clock cycles.
- Presents the tone as a 1-bit square output and as a signed 16-bit PCM sample with volume scaling, for the audio DAC serializer.
- Note changes take effect only at half-period boundaries, so no runt pulses reach the speaker.

Parameters:
- AMP, 16'h7FFF: peak sample magnitude at volume 0; positive, at most 16'h7FFF.
- MIN_DIV, 20'd2: smallest note_div treated as a valid note; below this is silence.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- note_div  input  20  requested full tone period in clk cycles; 0 means silence
- volume  input  3  attenuation, sample magnitude = AMP >> volume
- square  output  1  tone square wave, registered
- sample  output  16  signed PCM sample, registered, two's complement
- active  output  1  high while a tone is playing
- note_load  output  1  one-cycle pulse on the cycle a new period is latched

Behaviour:
- Reset (async, rst_n low):
  - active_div = 0, cnt = 0.
  - square = 0, sample = 0, active = 0, note_load = 0.
- Valid request:
  - req = note_div if note_div >= MIN_DIV, else 0.
  - half = active_div >> 1; odd periods truncate, so the real period is 2*half.
- IDLE state (active_div == 0):
  - cnt held at 0; square = 0; sample = 0; active = 0.
  - On a clock edge with req != 0: active_div <= req, cnt <= 0, square <= 1, active <= 1, note_load <= 1. The latch takes one cycle.
- PLAY state (active_div != 0):
  - cnt increments each cycle.
  - Boundary: cnt == half - 1. At a boundary, cnt <= 0 and square toggles.
  - If req != active_div at a boundary: active_div <= req, and note_load pulses.
    - If req == 0: square <= 0, active <= 0, return to IDLE.
    - Otherwise the new half-period starts with the toggled square level.
  - Changes to note_div between boundaries are ignored; no effect until the next boundary.
- Sample output, registered from the next-state square/active:
  - active and square = 1: +(AMP >> volume).
  - active and square = 0: -(AMP >> volume).
  - inactive: 0.
  - volume is sampled every cycle, so a volume change takes effect on the next edge.
- note_load is high for exactly one cycle per latch and never in consecutive cycles unless half == 1.
- Boundary conditions:
  - note_div = 1 is treated as silence.
  - note_div = 2 gives half = 1: square toggles every cycle.
  - note_div = 20'hFFFFF gives half = 524287; cnt must not overflow.
  - Re-requesting the same value at a boundary causes no note_load pulse.
  - Reset asserted mid-tone forces all outputs low immediately, without waiting for a clock edge.
  - After reset release, behaviour is as IDLE.

Test Plan:
- Reset then note_div = 8, volume = 0 -> one cycle later note_load = 1, active = 1. square runs 1,1,1,1,0,0,0,0 repeating. sample alternates +32767 and -32767 every 4 cycles.
- Playing note_div = 8, then switch to 12 mid-half-period -> current half completes at 4 cycles; note_load pulses at that boundary; subsequent halves are 6 cycles; no half shorter than 4.
- Playing note_div = 8, then set note_div = 0 -> square stays at its level until the boundary, then square = 0, sample = 0, active = 0. No further toggles.
- note_div = 1, then note_div = 2 -> 1 keeps the block idle with all outputs 0. 2 toggles square every cycle and note_load pulses once.
- Playing with volume stepped 0 -> 3 -> 7 -> sample magnitude becomes 32767, then 4095, then 255 on the edge after each change.
- Assert rst_n low mid-tone between clock edges -> square, sample, active and note_load go to 0 asynchronously. After release with note_div = 8, the tone restarts with square high.
